// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter and its prescaler.
// Imported by updown_mod_counter and counter_prescaler.
package updown_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A prescale of 1 still needs a one-bit phase register to stay well formed.
  function automatic int prescWidth(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-enable prescaler: emits one tick per PRESCALE enabled cycles.
// restart forces the phase back to 0 regardless of en.
module counter_prescaler
  import updown_mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = prescWidth(PRESCALE);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // The phase freezes while en is low, so a gap simply stretches the step period.
  assign tick = en && (phase_q == LAST_PHASE);

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with clear, clamped load, prescaled steps,
// wrap/saturate boundaries, terminal-count pulse and sticky overflow.
// Optional snapshot port pair enabled by UPDOWN_MOD_COUNTER_SNAPSHOT_EN.
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               PRESCALE = 1,
  parameter int               SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
`ifdef UPDOWN_MOD_COUNTER_SNAPSHOT_EN
  ,
  input  logic             snap,
  output logic [WIDTH-1:0] snap_val
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic restart;
  logic tick;
  logic step;
  logic atTop;
  logic atBottom;
  logic boundary;

  assign restart  = clr | load;
  assign step     = tick & ~restart;
  assign atTop    = (cnt_q == MAX);
  assign atBottom = (cnt_q == '0);
  assign boundary = step & ((up == DIR_UP) ? atTop : atBottom);

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .tick   (tick)
  );

  // Boundary steps either wrap or hold; the overflow set overrides a same-edge ovf_clr.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MAX) ? MAX : load_val;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (!atTop) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (SATURATE == MODE_WRAP) begin
          cnt_d = '0;
        end
      end else begin
        if (!atBottom) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (SATURATE == MODE_WRAP) begin
          cnt_d = MAX;
        end
      end
    end
    if (boundary) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

`ifdef UPDOWN_MOD_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q;

  // Captures the pre-update count, independent of clr/load on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (snap) begin
      snap_q <= cnt_q;
    end
  end

  assign snap_val = snap_q;
`endif

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the basic 8-bit enable counter.
- Adds configurable width and modulo, up/down direction, synchronous clear and load, and a prescaled step enable.
- Supports wrap or saturate mode, with a terminal-count pulse and a sticky overflow flag.
- Used as the general timer/event counter in lab designs and exercised by standalone testbenches.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX, 2**WIDTH-1, top count value; counting range is 0..MAX; MAX must be at least 1 and fit in WIDTH.
- PRESCALE, 1, number of enabled cycles per count step (1..65535).
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; qualifies the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load data.
- ovf_clr  in  1  clears the sticky overflow flag.
- cnt  out  WIDTH  current count, registered.
- tc  out  1  one-cycle terminal-count pulse, registered.
- ovf  out  1  sticky boundary-crossing flag, registered.

Behaviour:
- Reset (async, rst=1): cnt=0, tc=0, ovf=0, prescaler phase=0; held while rst is high.
- Sync priority per edge: clr > load > step.
- clr: cnt<=0, prescaler phase<=0, tc<=0.
- load: cnt<=min(load_val, MAX), prescaler phase<=0, tc<=0.
- Prescaler (sub-module):
  - phase counts 0..PRESCALE-1 on cycles with en=1; holds when en=0.
  - tick is asserted combinationally when en=1 and phase==PRESCALE-1; phase then returns to 0.
  - PRESCALE=1: tick equals en.
- step = tick and no clr/load this cycle.
- Step, up=1:
  - cnt<MAX: cnt+1.
  - cnt==MAX: wrap mode gives 0; saturate mode holds MAX.
- Step, up=0:
  - cnt>0: cnt-1.
  - cnt==0: wrap mode gives MAX; saturate mode holds 0.
- Boundary step (the two "cnt==MAX up" / "cnt==0 down" cases above):
  - tc=1 in the cycle after the edge, concurrent with the new cnt value; tc=0 otherwise.
  - ovf<=1 on the same edge.
- Latency: cnt updates on the edge where step is true; no further pipeline.
- ovf behaviour:
  - ovf_clr=1 clears ovf.
  - If a boundary step and ovf_clr occur on the same edge, the set wins (ovf=1).
  - clr and load do not affect ovf.
- Direction change takes effect on the next step; the prescaler phase is unaffected.
- en dropping mid-prescale freezes phase; resuming continues from the frozen phase.
- Arithmetic is done in WIDTH bits; no intermediate value exceeds MAX.

Optional Feature:
- Macro UPDOWN_MOD_COUNTER_SNAPSHOT_EN.
- Defined: adds input snap (1 bit) and output snap_val (WIDTH bits).
  - On an edge with snap=1, snap_val<=cnt as it was before that edge's update.
  - Reset value of snap_val is 0.
  - snap_val is independent of clr/load.
- Undefined: neither port exists; no snapshot register is built.

Decomposition:
- Shared package updown_mod_counter_pkg:
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - prescaler width function clog2-based: max(1, clog2(PRESCALE)).
- One sub-module, counter_prescaler: inputs clk, rst, en, restart; output tick; parameter PRESCALE.

Test Plan:
- Reset mid-count: WIDTH=8, cnt=37, assert rst asynchronously between edges -> cnt=0, tc=0, ovf=0 immediately; counting resumes from 0 after release.
- Up wrap: MAX=9, SATURATE=0, PRESCALE=1, en=1, up=1 from 0 -> sequence 0..9,0; tc high exactly one cycle with cnt=0; ovf=1 stays set until ovf_clr.
- Down saturate: MAX=9, SATURATE=1, load_val=2, up=0 -> cnt 2,1,0,0,0; tc pulses on each held step at 0; ovf=1.
- Prescale and enable gap: PRESCALE=3, en high for 4 cycles, low 2, high 2 -> cnt increments after enabled cycles 3 and 6 only; final cnt=2.
- Priority and clamp: clr=1, load=1, step on the same edge -> cnt=0; load alone with load_val=200, MAX=99 -> cnt=99; ovf_clr on the same edge as a wrap -> ovf=1.
- Snapshot (macro defined): cnt=5 counting up, snap=1 on one edge -> snap_val=5 while cnt=6.
